// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// Optional trap support is enabled with MULTICYCLE_CTRL_TRAP_EN.
package multicycle_pkg;

   typedef enum logic [3:0] {
      IDLE,
      BOOT,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      DONE,
      TRAP
   } state_t;

   localparam logic [6:0] OPC_LW   = 7'h03;
   localparam logic [6:0] OPC_IALU = 7'h13;
   localparam logic [6:0] OPC_SW   = 7'h23;
   localparam logic [6:0] OPC_R    = 7'h33;
   localparam logic [6:0] OPC_SB   = 7'h63;
   localparam logic [6:0] OPC_JAL  = 7'h6F;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   typedef struct packed {
      logic       int_sel;
      logic       pc_we;
      logic       ir_we;
      logic       reg_write;
      logic       alu_src;
      logic [2:0] op;
      logic       mem_read;
      logic       mem_write;
      logic       mem2reg;
      logic       busy;
      logic       done;
      logic       trap;
   } ctrl_t;

   function automatic logic is_legal(input logic [6:0] opc);
      return (opc == OPC_LW) || (opc == OPC_IALU) || (opc == OPC_SW) ||
             (opc == OPC_R)  || (opc == OPC_SB)   || (opc == OPC_JAL);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Moore decode of (state, latched opcode) into the datapath control bundle.
// Pure combinational; no input of the top reaches this block directly.
module ctrl_decode
   import multicycle_pkg::*;
(
   input  state_t     i_state,
   input  logic [6:0] i_opc,
   output ctrl_t      o_ctrl
);

   logic w_exec_retire;

   // Branches and unknown opcodes finish in EXEC; everything else moves on.
   assign w_exec_retire = !((i_opc == OPC_LW) || (i_opc == OPC_SW) ||
                            (i_opc == OPC_IALU) || (i_opc == OPC_R) ||
                            (i_opc == OPC_JAL));

   always_comb begin
      o_ctrl         = '0;
      o_ctrl.alu_src = 1'b1;
      o_ctrl.op      = ALU_ADD;

      if (i_state == EXEC || i_state == MEM || i_state == WB) begin
         if (i_opc == OPC_R) begin
            o_ctrl.alu_src = 1'b0;
         end else if (i_opc == OPC_SB) begin
            o_ctrl.alu_src = 1'b0;
            o_ctrl.op      = ALU_SUB;
         end
      end

      case (i_state)
         BOOT: begin
            o_ctrl.busy    = 1'b1;
            o_ctrl.int_sel = 1'b1;
            o_ctrl.pc_we   = 1'b1;
         end
         FETCH: begin
            o_ctrl.busy  = 1'b1;
            o_ctrl.ir_we = 1'b1;
         end
         DECODE: o_ctrl.busy = 1'b1;
         EXEC: begin
            o_ctrl.busy  = 1'b1;
            o_ctrl.pc_we = w_exec_retire;
         end
         MEM: begin
            o_ctrl.busy = 1'b1;
            if (i_opc == OPC_LW) begin
               o_ctrl.mem_read = 1'b1;
               o_ctrl.mem2reg  = 1'b1;
            end else begin
               o_ctrl.mem_write = 1'b1;
               o_ctrl.pc_we     = 1'b1;
            end
         end
         WB: begin
            o_ctrl.busy      = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.pc_we     = 1'b1;
            o_ctrl.mem2reg   = (i_opc == OPC_LW);
         end
         DONE:    o_ctrl.done = 1'b1;
         TRAP:    o_ctrl.trap = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the lab datapath: state register, latched
// opcode and retired-instruction counter. Trap output with MULTICYCLE_CTRL_TRAP_EN.
module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter logic [31:0] ENTRY_POINT = 32'h28,
   parameter int unsigned MAX_INSNS   = 43,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [6:0]       opcode,
   input  logic             zero,
   output logic [31:0]      entryPoint,
   output logic             INT,
   output logic             pc_we,
   output logic             ir_we,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic [2:0]       op,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Mem2Reg,
   output logic             busy,
   output logic             done,
`ifdef MULTICYCLE_CTRL_TRAP_EN
   output logic             trap,
`endif
   output logic [CNT_W-1:0] insn_count
);

   state_t           r_state;
   state_t           w_state_next;
   logic [6:0]       r_opc;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_inc;
   logic             w_retire;
   logic             w_hit_max;
   logic             w_boot;
   ctrl_t            w_ctrl;
   logic             w_unused_zero;

   // Branch resolution lives in the datapath; the flag is not needed here.
   assign w_unused_zero = zero;

   assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;
   assign w_hit_max   = (MAX_INSNS != 0) && (w_count_inc == CNT_W'(MAX_INSNS));
   assign w_boot      = (w_state_next == BOOT);

   always_comb begin
      w_state_next = r_state;
      w_retire     = 1'b0;
      case (r_state)
         IDLE, DONE, TRAP: if (start) w_state_next = BOOT;
         BOOT:   w_state_next = FETCH;
         FETCH:  w_state_next = DECODE;
         DECODE: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            w_state_next = is_legal(r_opc) ? EXEC : TRAP;
`else
            w_state_next = EXEC;
`endif
         end
         EXEC: begin
            if (r_opc == OPC_LW || r_opc == OPC_SW)
               w_state_next = MEM;
            else if (r_opc == OPC_IALU || r_opc == OPC_R || r_opc == OPC_JAL)
               w_state_next = WB;
            else
               w_retire = 1'b1;
         end
         MEM: begin
            if (r_opc == OPC_LW) w_state_next = WB;
            else                 w_retire = 1'b1;
         end
         WB:      w_retire = 1'b1;
         default: w_state_next = IDLE;
      endcase
      if (w_retire) w_state_next = w_hit_max ? DONE : FETCH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_opc   <= 7'h00;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == FETCH) r_opc <= opcode;
         if (w_boot)           r_count <= '0;
         else if (w_retire)    r_count <= w_count_inc;
      end
   end

   ctrl_decode u_decode (
      .i_state (r_state),
      .i_opc   (r_opc),
      .o_ctrl  (w_ctrl)
   );

   assign entryPoint = ENTRY_POINT;
   assign INT        = w_ctrl.int_sel;
   assign pc_we      = w_ctrl.pc_we;
   assign ir_we      = w_ctrl.ir_we;
   assign RegWrite   = w_ctrl.reg_write;
   assign ALUSrc     = w_ctrl.alu_src;
   assign op         = w_ctrl.op;
   assign MemRead    = w_ctrl.mem_read;
   assign MemWrite   = w_ctrl.mem_write;
   assign Mem2Reg    = w_ctrl.mem2reg;
   assign busy       = w_ctrl.busy;
   assign done       = w_ctrl.done;
   assign insn_count = r_count;

`ifdef MULTICYCLE_CTRL_TRAP_EN
   assign trap = w_ctrl.trap;
`else
   logic w_unused_trap;
   assign w_unused_trap = w_ctrl.trap;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (MAX_INSNS=3); covers both builds of
// MULTICYCLE_CTRL_TRAP_EN.
module tb_multicycle_ctrl;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start  = 1'b0;
   logic        zero   = 1'b0;
   logic [6:0]  opcode = 7'h00;

   logic [31:0] entryPoint;
   logic        INT, pc_we, ir_we, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
   logic        busy, done;
   logic [2:0]  op;
   logic [15:0] insn_count;
`ifdef MULTICYCLE_CTRL_TRAP_EN
   logic        trap;
`endif

   int n_checks = 0;
   int n_errors = 0;

   multicycle_ctrl #(.ENTRY_POINT(32'h28), .MAX_INSNS(3), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .opcode     (opcode),
      .zero       (zero),
      .entryPoint (entryPoint),
      .INT        (INT),
      .pc_we      (pc_we),
      .ir_we      (ir_we),
      .RegWrite   (RegWrite),
      .ALUSrc     (ALUSrc),
      .op         (op),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Mem2Reg    (Mem2Reg),
      .busy       (busy),
      .done       (done),
`ifdef MULTICYCLE_CTRL_TRAP_EN
      .trap       (trap),
`endif
      .insn_count (insn_count)
   );

   always #5 clk = ~clk;

   // {INT, pc_we, ir_we, RegWrite, MemRead, MemWrite, Mem2Reg, ALUSrc, op, busy, done}
   logic [12:0] w_ctl;
   assign w_ctl = {INT, pc_we, ir_we, RegWrite, MemRead, MemWrite, Mem2Reg,
                   ALUSrc, op, busy, done};

   localparam logic [12:0] C_IDLE    = 13'b0000_000_1_010_00;
   localparam logic [12:0] C_BOOT    = 13'b1100_000_1_010_10;
   localparam logic [12:0] C_FETCH   = 13'b0010_000_1_010_10;
   localparam logic [12:0] C_DECODE  = 13'b0000_000_1_010_10;
   localparam logic [12:0] C_EXEC_R  = 13'b0000_000_0_010_10;
   localparam logic [12:0] C_WB_R    = 13'b0101_000_0_010_10;
   localparam logic [12:0] C_EXEC_AD = 13'b0000_000_1_010_10;
   localparam logic [12:0] C_MEM_LW  = 13'b0000_101_1_010_10;
   localparam logic [12:0] C_WB_LW   = 13'b0101_001_1_010_10;
   localparam logic [12:0] C_MEM_SW  = 13'b0100_010_1_010_10;
   localparam logic [12:0] C_WB_I    = 13'b0101_000_1_010_10;
   localparam logic [12:0] C_DONE    = 13'b0000_000_1_010_01;
   localparam logic [12:0] C_EXEC_SB = 13'b0100_000_0_110_10;
   localparam logic [12:0] C_TRAP    = 13'b0000_000_1_010_00;
   localparam logic [12:0] C_EXEC_NP = 13'b0100_000_1_010_10;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic log_retire(input string name);
      $display("retired %s: insn_count=%0d", name, insn_count);
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("reset_ctl", 32'(w_ctl), 32'(C_IDLE));
      check("reset_cnt", 32'(insn_count), 0);
      check("entry_point", entryPoint, 32'h28);
      rst_n = 1'b1;
      step();
      check("idle_hold", 32'(w_ctl), 32'(C_IDLE));

      // R-type, opcode change after FETCH must not matter
      opcode = 7'h33;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("r_boot", 32'(w_ctl), 32'(C_BOOT));
      step();
      check("r_fetch", 32'(w_ctl), 32'(C_FETCH));
      step();
      opcode = 7'h63;
      check("r_decode", 32'(w_ctl), 32'(C_DECODE));
      step();
      check("r_exec", 32'(w_ctl), 32'(C_EXEC_R));
      step();
      check("r_wb", 32'(w_ctl), 32'(C_WB_R));
      opcode = 7'h03;
      step();
      log_retire("R");
      check("r_cnt", 32'(insn_count), 1);
      check("lw_fetch", 32'(w_ctl), 32'(C_FETCH));

      // lw
      step();
      step();
      check("lw_exec", 32'(w_ctl), 32'(C_EXEC_AD));
      step();
      check("lw_mem", 32'(w_ctl), 32'(C_MEM_LW));
      step();
      check("lw_wb", 32'(w_ctl), 32'(C_WB_LW));
      opcode = 7'h23;
      step();
      log_retire("lw");
      check("lw_cnt", 32'(insn_count), 2);

      // sw is the 3rd instruction: retires straight into DONE
      step();
      step();
      check("sw_exec", 32'(w_ctl), 32'(C_EXEC_AD));
      step();
      check("sw_mem", 32'(w_ctl), 32'(C_MEM_SW));
      step();
      log_retire("sw");
      check("sw_done", 32'(w_ctl), 32'(C_DONE));
      check("sw_cnt", 32'(insn_count), 3);
      step();
      check("done_sticky", 32'(w_ctl), 32'(C_DONE));

      // Restart from DONE, branch
      opcode = 7'h63;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("sb_boot", 32'(w_ctl), 32'(C_BOOT));
      check("sb_cnt_clr", 32'(insn_count), 0);
      step();
      step();
      step();
      check("sb_exec", 32'(w_ctl), 32'(C_EXEC_SB));
      opcode = 7'h7F;
      step();
      log_retire("beq");
      check("sb_cnt", 32'(insn_count), 1);
      check("sb_next_fetch", 32'(w_ctl), 32'(C_FETCH));

      // Illegal opcode
      step();
      check("ill_decode", 32'(w_ctl), 32'(C_DECODE));
      step();
`ifdef MULTICYCLE_CTRL_TRAP_EN
      check("trap_ctl", 32'(w_ctl), 32'(C_TRAP));
      check("trap_flag", 32'(trap), 1);
      step();
      step();
      check("trap_hold", 32'(w_ctl), 32'(C_TRAP));
      check("trap_sticky", 32'(trap), 1);
      check("trap_cnt", 32'(insn_count), 1);
      opcode = 7'h23;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("trap_exit", 32'(trap), 0);
      check("trap_boot", 32'(w_ctl), 32'(C_BOOT));
      step();
`else
      check("nop_exec", 32'(w_ctl), 32'(C_EXEC_NP));
      opcode = 7'h23;
      step();
      log_retire("nop");
      check("nop_cnt", 32'(insn_count), 2);
`endif

      // sw aborted by reset during MEM
      check("sw2_fetch", 32'(w_ctl), 32'(C_FETCH));
      step();
      step();
      step();
      check("sw2_mem", 32'(w_ctl), 32'(C_MEM_SW));
      rst_n = 1'b0;
      #1;
      check("rst_async_ctl", 32'(w_ctl), 32'(C_IDLE));
      check("rst_async_cnt", 32'(insn_count), 0);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_idle", 32'(w_ctl), 32'(C_IDLE));

      // Three I-ALU instructions, start while busy ignored
      opcode = 7'h13;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("i_boot", 32'(w_ctl), 32'(C_BOOT));
      step();
      for (int i = 1; i <= 3; i++) begin
         check($sformatf("i%0d_fetch", i), 32'(w_ctl), 32'(C_FETCH));
         if (i == 1) start = 1'b1;
         step();
         start = 1'b0;
         check($sformatf("i%0d_decode", i), 32'(w_ctl), 32'(C_DECODE));
         step();
         check($sformatf("i%0d_exec", i), 32'(w_ctl), 32'(C_EXEC_AD));
         step();
         check($sformatf("i%0d_wb", i), 32'(w_ctl), 32'(C_WB_I));
         step();
         log_retire("addi");
         check($sformatf("i%0d_cnt", i), 32'(insn_count), 32'(i));
      end
      check("i_done", 32'(w_ctl), 32'(C_DONE));
      step();
      check("i_done_hold", 32'(w_ctl), 32'(C_DONE));
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_boot", 32'(w_ctl), 32'(C_BOOT));
      check("restart_cnt", 32'(insn_count), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the single-cycle RISC-V lab datapath (yIF/yID/yEX/yDM/yWB/yPC).
- Replaces the bench-driven control loop: owns the control side of the datapath interface, where the datapath is the responder.
- Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB states.
- Per-state write enables and mux selects are generated from the latched opcode.

Parameters:
- ENTRY_POINT, 32'h28, PC value loaded through INT at boot.
- MAX_INSNS, 43, instructions to retire before halting; 0 = run forever.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins boot from IDLE or DONE.
- opcode  in  7  ins[6:0] from yIF; sampled only in FETCH.
- zero  in  1  ALU zero flag from yEX; informational only, branch resolution is in yPC.
- entryPoint  out  32  constant ENTRY_POINT.
- INT  out  1  PC source = entryPoint.
- pc_we  out  1  PC register load enable.
- ir_we  out  1  instruction register load enable.
- RegWrite  out  1  register file write enable.
- ALUSrc  out  1  1 = immediate, 0 = rd2.
- op  out  3  ALU op: 010 add, 110 subtract.
- MemRead  out  1  data memory read.
- MemWrite  out  1  data memory write.
- Mem2Reg  out  1  writeback select: 1 = memOut, 0 = z.
- busy  out  1  high in BOOT through WB.
- done  out  1  sticky; high in DONE.
- insn_count  out  CNT_W  instructions retired.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE and insn_count to 0.
  - All strobes (INT, pc_we, ir_we, RegWrite, MemRead, MemWrite) go to 0, as do busy and done.
  - ALUSrc=1, op=010, Mem2Reg=0.
  - Reset mid-instruction aborts with no further write strobe.
- Outputs are Moore-decoded from the state register and the latched opcode register (opc_q). There are no combinational paths from inputs to outputs.
- IDLE:
  - start moves to BOOT and clears insn_count.
- BOOT (1 cycle):
  - INT=1, pc_we=1, then FETCH.
- FETCH (1 cycle):
  - ir_we=1 and opc_q<=opcode, then DECODE.
- DECODE (1 cycle):
  - No strobes. Next state is EXEC, or TRAP if the opcode is illegal (see Optional Feature).
- EXEC:
  - Select values by opc_q:
    - 03 (lw) and 13 (I-ALU): ALUSrc=1, op=010.
    - 23 (sw): ALUSrc=1, op=010.
    - 33 (R): ALUSrc=0, op=010.
    - 63 (SB): ALUSrc=0, op=110.
    - 6F (jal): ALUSrc=1, op=010.
  - 63 retires here: pc_we=1, then FETCH.
  - 03 and 23 go to MEM.
  - 13, 33 and 6F go to WB.
- MEM:
  - 03: MemRead=1, Mem2Reg=1, then WB.
  - 23: MemWrite=1, pc_we=1, retire, then FETCH.
- WB:
  - RegWrite=1 and pc_we=1; Mem2Reg=1 only for 03. Retire, then FETCH.
  - ALUSrc and op keep their EXEC values through MEM and WB.
- Latency per instruction: lw 5, sw 4, R/I 4, jal 4, branch 3 cycles (FETCH..retire).
- Retire:
  - insn_count increments, saturating at all-ones.
  - If MAX_INSNS != 0 and the new count == MAX_INSNS, go to DONE instead of FETCH.
- DONE:
  - done=1, busy=0, no strobes.
  - start restarts boot and clears done and count.
- start while busy is ignored.
- At most one of RegWrite, MemWrite and pc_we-with-INT is high in any cycle, except that retire and WB coincide.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- Defined:
  - An opcode outside {03,13,23,33,63,6F} in DECODE goes to TRAP.
  - TRAP: no strobes; extra output trap=1 (sticky).
  - Exit only by reset or start.
- Undefined:
  - An illegal opcode executes as a NOP in 3 cycles: pc_we=1 in EXEC, retire counted.
  - No trap port.

Decomposition:
- Package multicycle_pkg:
  - State enum (IDLE, BOOT, FETCH, DECODE, EXEC, MEM, WB, DONE, TRAP).
  - Opcode constants OPC_LW=7'h03, OPC_IALU=7'h13, OPC_SW=7'h23, OPC_R=7'h33, OPC_SB=7'h63, OPC_JAL=7'h6F.
  - ALU_ADD=3'b010, ALU_SUB=3'b110.
- One sub-module, ctrl_decode: combinational map of (state, opc_q) to the control bundle. The top holds the state register, opc_q and the counter.

Test Plan:
- Reset, then start, then opcode 33: BOOT INT=1/pc_we=1; FETCH ir_we=1; EXEC ALUSrc=0 op=010; WB RegWrite=1 pc_we=1; insn_count=1 after 5 cycles from start.
- opcode 03: MEM MemRead=1 Mem2Reg=1; WB RegWrite=1 Mem2Reg=1; 5 cycles FETCH..retire.
- opcode 23 then 63: sw asserts MemWrite only in MEM, RegWrite never; beq EXEC op=110 ALUSrc=0 pc_we=1, retire in 3 cycles.
- MAX_INSNS=3 with opcode held at 13: done=1 and busy=0 after the 3rd WB; insn_count=3; start pulsed in DONE restarts with count 0.
- rst_n low during MEM of a sw: MemWrite drops the same instant; state IDLE; start pulsed while busy has no effect.
- opcode 7'h7F: with MULTICYCLE_CTRL_TRAP_EN, trap=1 after DECODE and no strobes thereafter; without it, 3-cycle NOP and insn_count+1.
